// File: rtl/rank_pifo_pkg.sv
// Shared definitions for the rank pipe / rank PIFO pair: default field widths,
// the packed storage entry and the per-slot update selector.
package rank_pifo_pkg;

    localparam int PIFO_RANK_WIDTH = 16;
    localparam int PIFO_META_WIDTH = 16;
    localparam int PIFO_DEPTH      = 16;

    typedef struct packed {
        logic                       valid;
        logic [PIFO_RANK_WIDTH-1:0] rank;
        logic [PIFO_META_WIDTH-1:0] meta;
    } pifo_entry_t;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_SHIFT_UP,
        SEL_SHIFT_DOWN,
        SEL_NEW
    } cell_sel_e;

    function automatic pifo_entry_t makeEntry(input logic [PIFO_RANK_WIDTH-1:0] rank,
                                              input logic [PIFO_META_WIDTH-1:0] meta);
        pifo_entry_t e;
        e.valid = 1'b1;
        e.rank  = rank;
        e.meta  = meta;
        return e;
    endfunction

endpackage

// File: rtl/rank_pifo_if.sv
// Bundle of the rank pipe pull handshake and the dequeue/status side of the PIFO.
// The PIFO uses the slave view; whoever feeds ranks and pops the head uses master.
interface rank_pifo_if import rank_pifo_pkg::*; #(
    parameter int RANK_WIDTH = PIFO_RANK_WIDTH,
    parameter int META_WIDTH = PIFO_META_WIDTH,
    parameter int DEPTH      = PIFO_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
);

    logic                  in_valid;
    logic [RANK_WIDTH-1:0] in_rank;
    logic [META_WIDTH-1:0] in_meta;
    logic                  in_remove;
    logic                  deq;
    logic                  deq_valid;
    logic [RANK_WIDTH-1:0] deq_rank;
    logic [META_WIDTH-1:0] deq_meta;
    logic [CNT_WIDTH-1:0]  count;
    logic                  full;

    modport master (
        output in_valid, in_rank, in_meta, deq,
        input  in_remove, deq_valid, deq_rank, deq_meta, count, full
    );

    modport slave (
        input  in_valid, in_rank, in_meta, deq,
        output in_remove, deq_valid, deq_rank, deq_meta, count, full
    );

endinterface

// File: rtl/rank_pifo_cell.sv
// One storage slot of the sorted PIFO. The slot only needs to know whether it and
// its neighbours hold ranks <= the incoming rank; because the array is sorted that
// compare vector is a thermometer code, which pins down the insert position locally.
module rank_pifo_cell import rank_pifo_pkg::*; #(
    parameter bit IS_HEAD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        selfLe_i,
    input  logic        lowerLe_i,
    input  logic        upperLe_i,
    input  pifo_entry_t lowerEntry_i,
    input  pifo_entry_t upperEntry_i,
    input  pifo_entry_t newEntry_i,
    input  logic        insert_i,
    input  logic        dequeue_i,
    output pifo_entry_t entry_o
);

    cell_sel_e   sel;
    pifo_entry_t entry_d;
    pifo_entry_t entry_q;

    // Choose the slot update; with insert+dequeue the new entry lands one below its insert-only position.
    always_comb begin
        sel = SEL_HOLD;
        if (insert_i && dequeue_i) begin
            if (upperLe_i) begin
                sel = SEL_SHIFT_DOWN;
            end else if (selfLe_i || IS_HEAD) begin
                sel = SEL_NEW;
            end
        end else if (insert_i) begin
            if (!selfLe_i) begin
                sel = (IS_HEAD || lowerLe_i) ? SEL_NEW : SEL_SHIFT_UP;
            end
        end else if (dequeue_i) begin
            sel = SEL_SHIFT_DOWN;
        end
    end

    // Next-state mux for the slot contents.
    always_comb begin
        entry_d = entry_q;
        case (sel)
            SEL_SHIFT_UP:   entry_d = lowerEntry_i;
            SEL_SHIFT_DOWN: entry_d = upperEntry_i;
            SEL_NEW:        entry_d = newEntry_i;
            default:        entry_d = entry_q;
        endcase
    end

    // Slot register; reset clears the valid bit and the payload so empty slots read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/rank_pifo.sv
// Register-based sorted PIFO fed by the rank pipe. Entries are kept sorted by
// ascending rank with arrival order as tie-break; slot 0 is the head and drives
// the dequeue outputs directly.
module rank_pifo import rank_pifo_pkg::*; #(
    parameter int RANK_WIDTH = PIFO_RANK_WIDTH,
    parameter int META_WIDTH = PIFO_META_WIDTH,
    parameter int DEPTH      = PIFO_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input logic       clk,
    input logic       rst,
    rank_pifo_if.slave bus
);

    pifo_entry_t          cellEntry  [DEPTH];
    pifo_entry_t          lowerEntry [DEPTH];
    pifo_entry_t          upperEntry [DEPTH];
    pifo_entry_t          newEntry;
    logic [DEPTH:0]       rankLe;
    logic [DEPTH-1:0]     lowerLe;
    logic                 accept;
    logic                 doDeq;
    logic                 isFull;
    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH-1:0] count_q;

    // Position compare vector; the extra top bit stands for the empty slot above the array.
    always_comb begin
        rankLe = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rankLe[k] = cellEntry[k].valid && (cellEntry[k].rank <= bus.in_rank);
        end
    end

    // Neighbour views for every slot; the ends see an empty entry.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            lowerEntry[k] = '0;
            upperEntry[k] = '0;
        end
        for (int k = 1; k < DEPTH; k++) begin
            lowerEntry[k] = cellEntry[k-1];
        end
        for (int k = 0; k < DEPTH - 1; k++) begin
            upperEntry[k] = cellEntry[k+1];
        end
    end

    assign lowerLe  = {rankLe[DEPTH-2:0], 1'b0};
    assign newEntry = makeEntry(bus.in_rank, bus.in_meta);
    assign doDeq    = bus.deq && cellEntry[0].valid;
    assign isFull   = (count_q == CNT_WIDTH'(DEPTH));
    assign accept   = bus.in_valid && (!isFull || doDeq);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        rank_pifo_cell #(
            .IS_HEAD (i == 0)
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .selfLe_i     (rankLe[i]),
            .lowerLe_i    (lowerLe[i]),
            .upperLe_i    (rankLe[i+1]),
            .lowerEntry_i (lowerEntry[i]),
            .upperEntry_i (upperEntry[i]),
            .newEntry_i   (newEntry),
            .insert_i     (accept),
            .dequeue_i    (doDeq),
            .entry_o      (cellEntry[i])
        );
    end

    // Occupancy moves only when exactly one of insert/dequeue happens.
    always_comb begin
        count_d = count_q;
        case ({accept, doDeq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.in_remove = accept && !rst;
    assign bus.deq_valid = cellEntry[0].valid;
    assign bus.deq_rank  = cellEntry[0].rank;
    assign bus.deq_meta  = cellEntry[0].meta;
    assign bus.count     = count_q;
    assign bus.full      = isFull;

endmodule
